// File: rtl/qdiv_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : qdiv_arbiter_if
//  Description : Request, divider and response bundle shared by qdiv_arbiter
//                (slave side) and the requesters/divider/consumer (master).
//  Revision    : 1.0 - initial release
// ============================================================================
interface qdiv_arbiter_if #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   i_req_valid;
    logic [NREQ*N-1:0] i_req_dividend;
    logic [NREQ*N-1:0] i_req_divisor;
    logic [NREQ-1:0]   o_req_ready;

    logic              o_div_start;
    logic [N-1:0]      o_div_dividend;
    logic [N-1:0]      o_div_divisor;
    logic [N-1:0]      i_div_quotient;
    logic              i_div_complete;
    logic              i_div_overflow;

    logic              o_rsp_valid;
    logic [IDW-1:0]    o_rsp_id;
    logic [N-1:0]      o_rsp_quotient;
    logic              o_rsp_overflow;
    logic              i_rsp_ready;

    logic              o_busy;

    modport slave (
        input  i_req_valid, i_req_dividend, i_req_divisor,
        input  i_div_quotient, i_div_complete, i_div_overflow,
        input  i_rsp_ready,
        output o_req_ready, o_div_start, o_div_dividend, o_div_divisor,
        output o_rsp_valid, o_rsp_id, o_rsp_quotient, o_rsp_overflow,
        output o_busy
    );

    modport master (
        output i_req_valid, i_req_dividend, i_req_divisor,
        output i_div_quotient, i_div_complete, i_div_overflow,
        output i_rsp_ready,
        input  o_req_ready, o_div_start, o_div_dividend, o_div_divisor,
        input  o_rsp_valid, o_rsp_id, o_rsp_quotient, o_rsp_overflow,
        input  o_busy
    );
endinterface
`default_nettype wire

// File: rtl/qdiv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : qdiv_arbiter
//  Description : Round-robin scheduler sharing one sequential qdiv divider
//                among NREQ requesters; returns id-tagged quotients.
//                Optional macro QDIV_ARB_DIVZERO_EN: zero divisors bypass the
//                divider and answer with a saturated, overflowing quotient.
//  Revision    : 1.0 - initial release
// ============================================================================
module qdiv_arbiter #(
    parameter int N    = 32,
    parameter int Q    = 15,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst_n,
    qdiv_arbiter_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    generate
        if (NREQ < 2 || NREQ > (1 << IDW) || Q < 0 || Q >= N) begin : g_cfg_error
            $error("qdiv_arbiter: invalid parameter combination");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [N-1:0]    dvd_q, dvd_d;
    logic [N-1:0]    dvs_q, dvs_d;
    logic [N-1:0]    quot_q, quot_d;
    logic            ovf_q, ovf_d;

    logic            w_any;
    logic [IDW-1:0]  w_gnt_idx;
    logic [NREQ-1:0] w_gnt_onehot;
    logic [N-1:0]    w_sel_dvd;
    logic [N-1:0]    w_sel_dvs;
    logic            w_start;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // First pending requester at or after the pointer, searching upward with wrap.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_any && bus.i_req_valid[wrap_idx(ptr_q, k)]) begin
                w_any     = 1'b1;
                w_gnt_idx = wrap_idx(ptr_q, k);
            end
        end
    end

    assign w_gnt_onehot = w_any ? (NREQ'(1) << w_gnt_idx) : '0;
    assign w_sel_dvd    = bus.i_req_dividend[int'(w_gnt_idx)*N +: N];
    assign w_sel_dvs    = bus.i_req_divisor[int'(w_gnt_idx)*N +: N];

`ifdef QDIV_ARB_DIVZERO_EN
    logic w_div_zero;
    assign w_div_zero = (w_sel_dvs[N-2:0] == '0);
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        ovf_d   = ovf_q;
        w_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    id_d  = w_gnt_idx;
                    dvd_d = w_sel_dvd;
                    dvs_d = w_sel_dvs;
                    ptr_d = (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
`ifdef QDIV_ARB_DIVZERO_EN
                    if (w_div_zero) begin
                        quot_d  = {w_sel_dvd[N-1] ^ w_sel_dvs[N-1], {(N-1){1'b1}}};
                        ovf_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_LAUNCH;
                    end
`else
                    state_d = S_LAUNCH;
`endif
                end
            end

            // The divider has no reset, so a start is only issued once it
            // reports idle; this also absorbs a stale run after our reset.
            S_LAUNCH: begin
                if (bus.i_div_complete) begin
                    w_start = 1'b1;
                    state_d = S_WAIT_BUSY;
                end
            end

            S_WAIT_BUSY: begin
                if (!bus.i_div_complete) begin
                    state_d = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                if (bus.i_div_complete) begin
                    quot_d  = bus.i_div_quotient;
                    ovf_d   = bus.i_div_overflow;
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            ovf_q   <= ovf_d;
        end
    end

    // Ready is combinational in IDLE; masking with reset keeps it low while
    // reset is held even if requesters are already pending.
    assign bus.o_req_ready    = (state_q == S_IDLE) ? (w_gnt_onehot & {NREQ{i_rst_n}}) : '0;
    assign bus.o_div_start    = w_start;
    assign bus.o_div_dividend = dvd_q;
    assign bus.o_div_divisor  = dvs_q;
    assign bus.o_rsp_valid    = (state_q == S_RESP);
    assign bus.o_rsp_id       = id_q;
    assign bus.o_rsp_quotient = quot_q;
    assign bus.o_rsp_overflow = ovf_q;
    assign bus.o_busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire
